// File: rtl/conv_sequencer_pkg.sv
// Shared types and width helpers for the convolution sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    DRAIN   = 3'd2,
    DISPLAY = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic {
    MODE_SERIAL   = 1'b0,
    MODE_PARALLEL = 1'b1
  } mode_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Bit width able to index n items, never narrower than one bit.
  function automatic int width_of(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/conv_sequencer_dwell_counter.sv
// Dwell timer for the display path: counts 0..DWELL_MAX while enabled.
module dwell_counter #(
  parameter int DWELL_MAX = 99999999,
  parameter int CNT_W     = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  // Next count: held at zero while disabled, wraps after the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for the convolution datapath: walks the output map,
// issues tap addresses (serial or row-parallel), delays result writes to
// match the MAC pipeline, then steps the display through every pixel.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IN_DIM    = 4,
  parameter int K_DIM     = 3,
  parameter int PIPE_LAT  = 2,
  parameter int DWELL_MAX = 99999999,
  parameter int CNT_W     = 27,
  localparam int OUT_DIM  = IN_DIM - K_DIM + 1,
  localparam int ADDR_W   = width_of(IN_DIM * IN_DIM),
  localparam int FADDR_W  = width_of(K_DIM * K_DIM),
  localparam int OADDR_W  = width_of(OUT_DIM * OUT_DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     issue_vld,
  output logic [K_DIM*ADDR_W-1:0]  addr_a,
  output logic [K_DIM*FADDR_W-1:0] addr_b,
  output logic [K_DIM-1:0]         lane_en,
  output logic                     acc_clr,
  output logic                     last_tap,
  output logic                     wr_en,
  output logic [OADDR_W-1:0]       wr_addr,
  output logic                     dis_en,
  output logic [OADDR_W-1:0]       dis_addr
);

  localparam int KW = width_of(K_DIM);
  localparam int OW = width_of(OUT_DIM);
  localparam int DW = width_of(PIPE_LAT);

  localparam logic [KW-1:0]      K_LAST = KW'(K_DIM - 1);
  localparam logic [OW-1:0]      O_LAST = OW'(OUT_DIM - 1);
  localparam logic [DW-1:0]      D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [OADDR_W-1:0] P_LAST = OADDR_W'(OUT_DIM * OUT_DIM - 1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [KW-1:0]       kx_q, kx_d, ky_q, ky_d;
  logic [OW-1:0]       ox_q, ox_d, oy_q, oy_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [OADDR_W-1:0]  pix_q, pix_d;

  logic                row_last_s;
  logic                pix_last_s;
  logic                tick_s;
  logic [OADDR_W-1:0]  pix_lin_s;

  logic                     busy_d, done_d, issue_d, acc_clr_d, last_d, dis_en_d;
  logic [K_DIM*ADDR_W-1:0]  addr_a_d;
  logic [K_DIM*FADDR_W-1:0] addr_b_d;
  logic [K_DIM-1:0]         lane_en_d;
  logic [OADDR_W-1:0]       dis_addr_d;

  logic                wr_vld_q [PIPE_LAT];
  logic [OADDR_W-1:0]  wr_adr_q [PIPE_LAT];

  // In parallel mode a whole kernel row goes out per cycle, so every cycle ends a row.
  assign row_last_s = (mode_q == MODE_PARALLEL) || (kx_q == K_LAST);
  assign pix_last_s = row_last_s && (ky_q == K_LAST);
  // Linear result address of the pixel currently being issued.
  assign pix_lin_s  = OADDR_W'(32'(oy_q) * 32'(OUT_DIM) + 32'(ox_q));

  dwell_counter #(
    .DWELL_MAX (DWELL_MAX),
    .CNT_W     (CNT_W)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == DISPLAY),
    .tick (tick_s)
  );

  // Next-state and counter sequencing; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    drain_d = drain_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          mode_d  = mode_e'(mode);
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          drain_d = '0;
          pix_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (pix_last_s) begin
          kx_d = '0;
          ky_d = '0;
          if (ox_q == O_LAST) begin
            ox_d = '0;
            if (oy_q == O_LAST) begin
              oy_d    = '0;
              state_d = DRAIN;
            end else begin
              oy_d = oy_q + OW'(1);
            end
          end else begin
            ox_d = ox_q + OW'(1);
          end
        end else if (row_last_s) begin
          kx_d = '0;
          ky_d = ky_q + KW'(1);
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          drain_d = '0;
          state_d = DISPLAY;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DISPLAY: begin
        if (tick_s) begin
          if (pix_q == P_LAST) begin
            pix_d   = '0;
            state_d = DONE;
          end else begin
            pix_d = pix_q + OADDR_W'(1);
          end
        end else begin
          pix_d = pix_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      kx_d    = '0;
      ky_d    = '0;
      ox_d    = '0;
      oy_d    = '0;
      drain_d = '0;
      pix_d   = '0;
    end else begin
      mode_d = mode_d;
    end
  end

  // Output values for the coming cycle, derived from next state and counters.
  always_comb begin
    logic [31:0] a_v;
    logic [31:0] b_v;
    a_v        = '0;
    b_v        = '0;
    addr_a_d   = '0;
    addr_b_d   = '0;
    lane_en_d  = '0;
    issue_d    = (state_d == COMPUTE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    dis_en_d   = (state_d == DISPLAY);
    dis_addr_d = dis_en_d ? pix_d : '0;
    for (int j = 0; j < K_DIM; j++) begin
      if (issue_d && ((j == 0) || (mode_d == MODE_PARALLEL))) begin
        a_v = (32'(oy_d) + 32'(ky_d)) * 32'(IN_DIM) + 32'(ox_d) + 32'(kx_d) + 32'(j);
        b_v = 32'(K_DIM * K_DIM - 1) - (32'(ky_d) * 32'(K_DIM) + 32'(kx_d) + 32'(j));
        addr_a_d[j*ADDR_W +: ADDR_W]   = a_v[ADDR_W-1:0];
        addr_b_d[j*FADDR_W +: FADDR_W] = b_v[FADDR_W-1:0];
        lane_en_d[j]                   = 1'b1;
      end else begin
        lane_en_d[j] = 1'b0;
      end
    end
    acc_clr_d = issue_d && (ky_d == '0) && (kx_d == '0);
    last_d    = issue_d && (ky_d == K_LAST) &&
                ((mode_d == MODE_PARALLEL) || (kx_d == K_LAST));
  end

  // State, mode and walk counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_SERIAL;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      drain_q <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      drain_q <= drain_d;
      pix_q   <= pix_d;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_vld <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      lane_en   <= '0;
      acc_clr   <= 1'b0;
      last_tap  <= 1'b0;
      dis_en    <= 1'b0;
      dis_addr  <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      issue_vld <= issue_d;
      addr_a    <= addr_a_d;
      addr_b    <= addr_b_d;
      lane_en   <= lane_en_d;
      acc_clr   <= acc_clr_d;
      last_tap  <= last_d;
      dis_en    <= dis_en_d;
      dis_addr  <= dis_addr_d;
    end
  end

  // Result-write delay line matching the MAC latency; abort discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_vld_q[i] <= 1'b0;
        wr_adr_q[i] <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_vld_q[i] <= 1'b0;
        wr_adr_q[i] <= '0;
      end
    end else begin
      wr_vld_q[0] <= last_tap;
      wr_adr_q[0] <= last_tap ? pix_lin_s : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_vld_q[i] <= wr_vld_q[i-1];
        wr_adr_q[i] <= wr_adr_q[i-1];
      end
    end
  end

  assign wr_en   = wr_vld_q[PIPE_LAT-1];
  assign wr_addr = wr_adr_q[PIPE_LAT-1];

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench: IN=4/K=3 (DWELL_MAX=3) in both modes with abort, restart,
// start-while-busy and reset-in-display cases, plus IN=5/K=2 (DWELL_MAX=0).
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start0, mode0, abort0, start1, mode1, abort1;

  logic        busy0, done0, iv0, clr0, lt0, wr0, de0;
  logic [11:0] a0, b0;
  logic [2:0]  le0;
  logic [1:0]  wa0, da0;

  logic        busy1, done1, iv1, clr1, lt1, wr1, de1;
  logic [9:0]  a1;
  logic [3:0]  b1;
  logic [1:0]  le1;
  logic [3:0]  wa1, da1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_sequencer #(.IN_DIM(4), .K_DIM(3), .PIPE_LAT(2), .DWELL_MAX(3), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .abort(abort0),
    .busy(busy0), .done(done0), .issue_vld(iv0), .addr_a(a0), .addr_b(b0),
    .lane_en(le0), .acc_clr(clr0), .last_tap(lt0), .wr_en(wr0), .wr_addr(wa0),
    .dis_en(de0), .dis_addr(da0));

  conv_sequencer #(.IN_DIM(5), .K_DIM(2), .PIPE_LAT(2), .DWELL_MAX(0), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .abort(abort1),
    .busy(busy1), .done(done1), .issue_vld(iv1), .addr_a(a1), .addr_b(b1),
    .lane_en(le1), .acc_clr(clr1), .last_tap(lt1), .wr_en(wr1), .wr_addr(wa1),
    .dis_en(de1), .dis_addr(da1));

  typedef struct {
    int         cyc;
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  le;
    logic        clr;
    logic        lst;
  } iss_t;

  typedef struct {
    logic mode;
    int   n_iss;
    int   n_clr;
    int   n_wr;
    int   n_dis;
  } run_t;

  typedef struct {
    int a;
    int b;
  } tap_t;

  iss_t iss0[$], iss1[$];
  int lt0_q[$], wr0_c[$], wr0_a[$], dis0_c[$], dis0_a[$];
  int lt1_q[$], wr1_c[$], wr1_a[$], dis1_c[$], dis1_a[$];
  int done0_n, done1_n;

  // Log every cycle's activity of both instances.
  always @(negedge clk) begin
    iss_t r;
    if (!rst) begin
      if (iv0) begin
        r.cyc = cyc; r.a = a0; r.b = b0; r.le = le0; r.clr = clr0; r.lst = lt0;
        iss0.push_back(r);
      end
      if (lt0) lt0_q.push_back(cyc);
      if (wr0) begin wr0_c.push_back(cyc); wr0_a.push_back(int'(wa0)); end
      if (de0) begin dis0_c.push_back(cyc); dis0_a.push_back(int'(da0)); end
      if (done0) done0_n++;
      if (iv1) begin
        r.cyc = cyc; r.a = {2'b00, a1}; r.b = {8'h00, b1}; r.le = {1'b0, le1};
        r.clr = clr1; r.lst = lt1;
        iss1.push_back(r);
      end
      if (lt1) lt1_q.push_back(cyc);
      if (wr1) begin wr1_c.push_back(cyc); wr1_a.push_back(int'(wa1)); end
      if (de1) begin dis1_c.push_back(cyc); dis1_a.push_back(int'(da1)); end
      if (done1) done1_n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    iss0.delete(); lt0_q.delete(); wr0_c.delete(); wr0_a.delete(); dis0_c.delete(); dis0_a.delete();
    iss1.delete(); lt1_q.delete(); wr1_c.delete(); wr1_a.delete(); dis1_c.delete(); dis1_a.delete();
    done0_n = 0;
    done1_n = 0;
  endtask

  // Pulse start for one cycle; sc is the cycle count just before the sampling edge.
  task automatic pulse_start(input int d, input logic m, output int sc);
    @(posedge clk); #1;
    if (d == 0) begin mode0 = m; start0 = 1'b1; end
    else begin mode1 = m; start1 = 1'b1; end
    sc = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Bounded wait: 0 = done0, 1 = done1, 2 = dis_en of dut0.
  task automatic wait_for(input int what, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      case (what)
        0: ok = done0;
        1: ok = done1;
        2: ok = de0;
        default: ok = 1'b0;
      endcase
      if (ok) break;
    end
  endtask

  // Compare a complete dut0 run against the reference walk.
  task automatic check_run0(input run_t r, input int sc);
    int n, p, t, oy, ox, ky, kx, nclr;
    logic [11:0] ea, eb;
    logic [2:0]  ele;
    logic        eclr, elst;
    chk("iss_count", iss0.size(), r.n_iss);
    n = (iss0.size() < r.n_iss) ? iss0.size() : r.n_iss;
    nclr = 0;
    for (int i = 0; i < n; i++) begin
      ea = '0; eb = '0;
      if (r.mode == 1'b0) begin
        p = i / 9; t = i % 9; ky = t / 3; kx = t % 3; oy = p / 2; ox = p % 2;
        ea[3:0] = 4'((oy + ky) * 4 + ox + kx);
        eb[3:0] = 4'(8 - t);
        ele = 3'b001; eclr = (t == 0); elst = (t == 8);
      end else begin
        p = i / 3; ky = i % 3; oy = p / 2; ox = p % 2;
        for (int j = 0; j < 3; j++) begin
          ea[j*4 +: 4] = 4'((oy + ky) * 4 + ox + j);
          eb[j*4 +: 4] = 4'(8 - (ky * 3 + j));
        end
        ele = 3'b111; eclr = (ky == 0); elst = (ky == 2);
      end
      chk("iss_cycle", iss0[i].cyc, sc + 1 + i);
      chk("addr_a", iss0[i].a, ea);
      chk("addr_b", iss0[i].b, eb);
      chk("lane_en", iss0[i].le, ele);
      chk("acc_clr", iss0[i].clr, eclr);
      chk("last_tap", iss0[i].lst, elst);
      if (iss0[i].clr) nclr++;
    end
    chk("clr_count", nclr, r.n_clr);
    chk("wr_count", wr0_c.size(), r.n_wr);
    for (int k = 0; k < wr0_c.size() && k < lt0_q.size(); k++) begin
      chk("wr_addr", wr0_a[k], k);
      chk("wr_latency", wr0_c[k] - lt0_q[k], 2);
    end
    chk("dis_cycles", dis0_c.size(), r.n_dis);
    for (int k = 0; k < dis0_c.size(); k++) begin
      chk("dis_addr", dis0_a[k], k / 4);
      chk("dis_cycle", dis0_c[k], dis0_c[0] + k);
    end
    if (dis0_c.size() > 0 && n > 0) chk("drain_len", dis0_c[0] - iss0[n-1].cyc, 3);
    chk("done_count", done0_n, 1);
  endtask

  run_t runs[2];
  tap_t first9[9];

  initial begin
    int sc;
    bit ok;
    rst = 1'b1;
    start0 = 1'b0; mode0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; abort1 = 1'b0;
    runs[0] = '{1'b0, 36, 4, 4, 16};
    runs[1] = '{1'b1, 12, 4, 4, 16};
    first9[0] = '{0, 8};  first9[1] = '{1, 7};  first9[2] = '{2, 6};
    first9[3] = '{4, 5};  first9[4] = '{5, 4};  first9[5] = '{6, 3};
    first9[6] = '{8, 2};  first9[7] = '{9, 1};  first9[8] = '{10, 0};
    clear_logs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_issue", iv0, 0);
    chk("rst_addr_a", a0, 0);
    chk("rst_wr_en", wr0, 0);
    chk("rst_dis_en", de0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_lane_en1", le1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven full runs on dut0
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      pulse_start(0, runs[r].mode, sc);
      wait_for(0, 400, ok);
      chk("done_seen", ok, 1);
      repeat (2) @(negedge clk);
      chk("busy_after_done", busy0, 0);
      check_run0(runs[r], sc);
      if (runs[r].mode == 1'b0) begin
        for (int i = 0; i < 9 && i < iss0.size(); i++) begin
          chk("ser_first_a", iss0[i].a, first9[i].a);
          chk("ser_first_b", iss0[i].b, first9[i].b);
        end
      end else if (iss0.size() > 0) begin
        chk("par_first_a", iss0[0].a, 12'h210);
        chk("par_first_b", iss0[0].b, 12'h678);
      end
    end

    // Abort in the 5th serial COMPUTE cycle, then restart
    clear_logs();
    pulse_start(0, 1'b0, sc);
    repeat (4) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk); #1 abort0 = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy0, 0);
    chk("abort_issue", iv0, 0);
    chk("abort_iss_count", iss0.size(), 5);
    repeat (10) @(negedge clk);
    chk("abort_no_wr", wr0_c.size(), 0);
    clear_logs();
    pulse_start(0, 1'b0, sc);
    wait_for(0, 400, ok);
    chk("restart_done", ok, 1);
    chk("restart_first_cyc", (iss0.size() > 0) ? iss0[0].cyc : -1, sc + 1);
    chk("restart_first_a", (iss0.size() > 0) ? iss0[0].a : 12'hfff, 0);
    chk("restart_wr_count", wr0_c.size(), 4);

    // Abort in parallel mode while a write is in flight
    clear_logs();
    pulse_start(0, 1'b1, sc);
    repeat (3) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk); #1 abort0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_iss_count", iss0.size(), 4);
    chk("flush_last_taps", lt0_q.size(), 1);
    chk("flush_no_wr", wr0_c.size(), 0);
    chk("flush_busy", busy0, 0);

    // start during DISPLAY is ignored
    clear_logs();
    pulse_start(0, 1'b0, sc);
    wait_for(2, 400, ok);
    chk("dis_reached", ok, 1);
    @(posedge clk); #1 start0 = 1'b1; mode0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_for(0, 100, ok);
    chk("busy_start_done", ok, 1);
    repeat (6) @(negedge clk);
    chk("busy_start_iss", iss0.size(), 36);
    chk("busy_start_dis", dis0_c.size(), 16);
    chk("busy_start_done_n", done0_n, 1);
    chk("busy_start_idle", busy0, 0);

    // Reset during DISPLAY: outputs clear immediately, no done
    clear_logs();
    pulse_start(0, 1'b0, sc);
    wait_for(2, 400, ok);
    chk("dis_reached2", ok, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_dis_en", de0, 0);
    chk("arst_dis_addr", da0, 0);
    chk("arst_done", done0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_no_done", done0_n, 0);
    chk("arst_idle", busy0, 0);

    // IN=5, K=2 serial on dut1 (DWELL_MAX = 0)
    clear_logs();
    pulse_start(1, 1'b0, sc);
    wait_for(1, 400, ok);
    chk("k2_done", ok, 1);
    repeat (2) @(negedge clk);
    chk("k2_iss_count", iss1.size(), 64);
    if (iss1.size() == 64) begin
      chk("k2_a0", iss1[0].a, 0);
      chk("k2_a1", iss1[1].a, 1);
      chk("k2_a2", iss1[2].a, 5);
      chk("k2_a3", iss1[3].a, 6);
      chk("k2_b0", iss1[0].b, 3);
      chk("k2_b3", iss1[3].b, 0);
      chk("k2_last_a", iss1[63].a, 24);
      chk("k2_last_b", iss1[63].b, 0);
      chk("k2_last_cyc", iss1[63].cyc, sc + 64);
      chk("k2_lane_en", iss1[63].le, 1);
    end
    chk("k2_wr_count", wr1_c.size(), 16);
    for (int k = 0; k < wr1_c.size() && k < lt1_q.size(); k++) begin
      chk("k2_wr_addr", wr1_a[k], k);
      chk("k2_wr_latency", wr1_c[k] - lt1_q[k], 2);
    end
    chk("k2_dis_cycles", dis1_c.size(), 16);
    for (int k = 0; k < dis1_c.size(); k++) begin
      chk("k2_dis_addr", dis1_a[k], k);
      chk("k2_dis_cycle", dis1_c[k], dis1_c[0] + k);
    end
    chk("k2_done_n", done1_n, 1);
    chk("k2_idle", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
